dcache_port_arb: RTL and testbench

- Single-ported D-cache access arbiter and sequencer, sitting between the memory pipeline stage (load requester) and the writeback stage (store requester).
- Grants the one cache port to one requester at a time.
- Splits spilled (line-crossing) accesses into two back-to-back cache beats and returns each load beat, tagged, for the mem stage to merge.
- Enforces store priority, bounded by a load-starvation limit.

---
 rtl/dcache_port_arb_pkg.sv | 21 ++
 rtl/dcache_port_arb_if.sv | 59 +++++
 rtl/dcache_port_arb_starve_ctr.sv | 32 +++
 rtl/dcache_port_arb.sv | 182 ++++++++++++++++++
 tb/tb_dcache_port_arb.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_port_arb_pkg.sv
// dcache_arb_pkg
// Shared definitions for the D-cache port arbiter and the mem pipe:
//   PA_W / DATA_W   physical address and cache data widths
//   ST_*            3-bit encoding of the arbiter FSM states
//   is_rd_state()   true while a load owns the cache port
package dcache_arb_pkg;

    localparam int PA_W   = 15;
    localparam int DATA_W = 32;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_ISS  = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_WR_ISS  = 3'd3;
    localparam logic [2:0] ST_DRAIN   = 3'd4;

    function automatic logic is_rd_state(input logic [2:0] st);
        return (st == ST_RD_ISS) || (st == ST_RD_WAIT);
    endfunction

endpackage

// File: rtl/dcache_port_arb_if.sv
// dcache_port_arb_if
// Bundles the three buses around the arbiter:
//   rd_*  load requester (mem stage) and its beat-tagged data return
//   wr_*  store requester (writeback stage)
//   dc_*  the single cache port
// Modports: slave = the arbiter, master = requesters plus cache.
interface dcache_port_arb_if;
    import dcache_arb_pkg::*;

    logic              rd_req;
    logic [PA_W-1:0]   rd_pa1;
    logic [PA_W-1:0]   rd_pa2;
    logic [1:0]        rd_size1;
    logic [1:0]        rd_size2;
    logic              rd_spill;
    logic              rd_flush;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_v;
    logic              rd_beat;
    logic              rd_ack;

    logic              wr_req;
    logic [PA_W-1:0]   wr_pa1;
    logic [PA_W-1:0]   wr_pa2;
    logic [1:0]        wr_size1;
    logic [1:0]        wr_size2;
    logic [DATA_W-1:0] wr_data1;
    logic [DATA_W-1:0] wr_data2;
    logic              wr_spill;
    logic              wr_ack;

    logic              dc_req;
    logic              dc_we;
    logic [PA_W-1:0]   dc_pa;
    logic [1:0]        dc_size;
    logic [DATA_W-1:0] dc_wdata;
    logic              dc_ready;
    logic [DATA_W-1:0] dc_rdata;
    logic              dc_rdata_v;

    modport slave (
        input  rd_req, rd_pa1, rd_pa2, rd_size1, rd_size2, rd_spill, rd_flush,
        output rd_data, rd_data_v, rd_beat, rd_ack,
        input  wr_req, wr_pa1, wr_pa2, wr_size1, wr_size2, wr_data1, wr_data2, wr_spill,
        output wr_ack,
        output dc_req, dc_we, dc_pa, dc_size, dc_wdata,
        input  dc_ready, dc_rdata, dc_rdata_v
    );

    modport master (
        output rd_req, rd_pa1, rd_pa2, rd_size1, rd_size2, rd_spill, rd_flush,
        input  rd_data, rd_data_v, rd_beat, rd_ack,
        output wr_req, wr_pa1, wr_pa2, wr_size1, wr_size2, wr_data1, wr_data2, wr_spill,
        input  wr_ack,
        input  dc_req, dc_we, dc_pa, dc_size, dc_wdata,
        output dc_ready, dc_rdata, dc_rdata_v
    );

endinterface

// File: rtl/dcache_port_arb_starve_ctr.sv
// starve_ctr
// Saturating load-starvation counter.
//   clk, rst  clock, synchronous active-high reset
//   inc       count one more lost cycle (ignored once saturated)
//   clr       clear; wins over inc
//   at_max    counter has reached MAX_VAL
module starve_ctr #(
    parameter int CNT_W   = 3,
    parameter int MAX_VAL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_VAL);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && cnt != MAX_C) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign at_max = (cnt == MAX_C);

endmodule

// File: rtl/dcache_port_arb.sv
// dcache_port_arb
// Arbitrates the single D-cache port between the load requester (mem
// stage) and the store requester (writeback stage). Stores have priority
// unless a load has lost STARVE_MAX cycles in a row. Line-crossing
// (spill) accesses go out as two beats; each load beat is returned with
// its beat index so the mem stage can merge them.
//   clk, rst  clock, synchronous active-high reset
//   bus       dcache_port_arb_if.slave (rd_*, wr_*, dc_* buses)
module dcache_port_arb
    import dcache_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    dcache_port_arb_if.slave bus
);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic              beat;
    logic              spill_q;
    logic [PA_W-1:0]   pa1_q;
    logic [PA_W-1:0]   pa2_q;
    logic [1:0]        size1_q;
    logic [1:0]        size2_q;
    logic [DATA_W-1:0] wdata1_q;
    logic [DATA_W-1:0] wdata2_q;

    logic rd_go;
    logic wr_go;
    logic at_max;
    logic last_beat;
    logic starve_inc;
    logic starve_clr;

    // Grant decisions are only acted on in IDLE.
    assign rd_go     = bus.rd_req && !bus.rd_flush && (!bus.wr_req || at_max);
    assign wr_go     = !rd_go && bus.wr_req;
    assign last_beat = !spill_q || beat;

    // A load loses a cycle whenever it is waiting and does not own the port.
    assign starve_inc = bus.rd_req && !bus.rd_flush && !is_rd_state(state);
    assign starve_clr = !bus.rd_req || (state == ST_IDLE && rd_go);

    starve_ctr #(
        .CNT_W  (CNT_W),
        .MAX_VAL(STARVE_MAX)
    ) u_starve_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .at_max(at_max)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request fields are captured at grant so requester changes during the
    // access cannot disturb it; beat moves to 1 only after beat 0 finished.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat     <= 1'b0;
            spill_q  <= 1'b0;
            pa1_q    <= '0;
            pa2_q    <= '0;
            size1_q  <= '0;
            size2_q  <= '0;
            wdata1_q <= '0;
            wdata2_q <= '0;
        end else if (state == ST_IDLE && rd_go) begin
            beat    <= 1'b0;
            spill_q <= bus.rd_spill;
            pa1_q   <= bus.rd_pa1;
            pa2_q   <= bus.rd_pa2;
            size1_q <= bus.rd_size1;
            size2_q <= bus.rd_size2;
        end else if (state == ST_IDLE && wr_go) begin
            beat     <= 1'b0;
            spill_q  <= bus.wr_spill;
            pa1_q    <= bus.wr_pa1;
            pa2_q    <= bus.wr_pa2;
            size1_q  <= bus.wr_size1;
            size2_q  <= bus.wr_size2;
            wdata1_q <= bus.wr_data1;
            wdata2_q <= bus.wr_data2;
        end else if (!last_beat &&
                     ((state == ST_RD_WAIT && bus.dc_rdata_v && !bus.rd_flush) ||
                      (state == ST_WR_ISS && bus.dc_ready))) begin
            beat <= 1'b1;
        end
    end

    // A flush before issue simply abandons the load; once a read is in
    // flight its response must still be swallowed, hence DRAIN.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (rd_go) begin
                    state_nxt = ST_RD_ISS;
                end else if (wr_go) begin
                    state_nxt = ST_WR_ISS;
                end
            end
            ST_RD_ISS: begin
                if (bus.rd_flush) begin
                    state_nxt = bus.dc_ready ? ST_DRAIN : ST_IDLE;
                end else if (bus.dc_ready) begin
                    state_nxt = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (bus.dc_rdata_v) begin
                    state_nxt = (bus.rd_flush || last_beat) ? ST_IDLE : ST_RD_ISS;
                end else if (bus.rd_flush) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_WR_ISS: begin
                if (bus.dc_ready && last_beat) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (bus.dc_rdata_v) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are forced low during reset so a transaction interrupted by
    // reset never produces a stray ack or cache access.
    always_comb begin
        bus.dc_req    = 1'b0;
        bus.dc_we     = 1'b0;
        bus.dc_pa     = '0;
        bus.dc_size   = '0;
        bus.dc_wdata  = '0;
        bus.rd_data   = '0;
        bus.rd_data_v = 1'b0;
        bus.rd_beat   = 1'b0;
        bus.rd_ack    = 1'b0;
        bus.wr_ack    = 1'b0;
        if (!rst) begin
            case (state)
                ST_RD_ISS: begin
                    bus.dc_req  = 1'b1;
                    bus.dc_pa   = beat ? pa2_q : pa1_q;
                    bus.dc_size = beat ? size2_q : size1_q;
                end
                ST_RD_WAIT: begin
                    if (bus.dc_rdata_v && !bus.rd_flush) begin
                        bus.rd_data   = bus.dc_rdata;
                        bus.rd_data_v = 1'b1;
                        bus.rd_beat   = beat;
                        bus.rd_ack    = last_beat;
                    end
                end
                ST_WR_ISS: begin
                    bus.dc_req   = 1'b1;
                    bus.dc_we    = 1'b1;
                    bus.dc_pa    = beat ? pa2_q : pa1_q;
                    bus.dc_size  = beat ? size2_q : size1_q;
                    bus.dc_wdata = beat ? wdata2_q : wdata1_q;
                    bus.wr_ack   = bus.dc_ready && last_beat;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_port_arb.sv
// tb_dcache_port_arb
// Self-checking bench for dcache_port_arb: a table of single transactions
// plus hand-written flush, reset and starvation sequences. Expected cache
// issues and load beats are queued when stimulus is driven and compared
// by a monitor as the DUT produces them. A small cache model answers reads
// with a word derived from the address after a configurable latency.
module tb_dcache_port_arb;
    import dcache_arb_pkg::*;

    typedef struct {
        bit                is_wr;
        bit                spill;
        logic [PA_W-1:0]   pa1;
        logic [PA_W-1:0]   pa2;
        logic [1:0]        size1;
        logic [1:0]        size2;
        logic [DATA_W-1:0] wd1;
        logic [DATA_W-1:0] wd2;
        int                lat;
        int                stall;
        logic [DATA_W-1:0] exp_rd1;
        logic [DATA_W-1:0] exp_rd2;
    } vec_t;

    typedef struct {
        bit                we;
        logic [PA_W-1:0]   pa;
        logic [1:0]        size;
        logic [DATA_W-1:0] wdata;
    } iss_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        bit                beat;
        bit                ack;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_port_arb_if bus ();

    dcache_port_arb #(
        .STARVE_MAX(4),
        .CNT_W     (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   rd_lat = 2;
    int   rdv_seen = 0;
    int   rd_ack_cnt = 0;
    int   wr_ack_cnt = 0;
    iss_t iss_q[$];
    rsp_t rsp_q[$];
    iss_t mon_iss;
    rsp_t mon_rsp;
    vec_t vecs[7];

    function automatic logic [DATA_W-1:0] mem_word(input logic [PA_W-1:0] pa);
        if (pa == 15'h0100) return 32'hDEADBEEF;
        return {2'b10, pa, pa};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Cache model: latches each read issue and returns its data rd_lat
    // cycles later as a one-cycle dc_rdata_v pulse.
    initial begin : responder
        int              cnt;
        logic [PA_W-1:0] pa_q;
        cnt = 0;
        pa_q = '0;
        bus.dc_rdata_v = 1'b0;
        bus.dc_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt = 0;
            end else if (bus.dc_req && bus.dc_ready && !bus.dc_we) begin
                cnt = rd_lat;
                pa_q = bus.dc_pa;
            end
            @(posedge clk);
            #1;
            bus.dc_rdata_v = 1'b0;
            bus.dc_rdata = '0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.dc_rdata_v = 1'b1;
                    bus.dc_rdata = mem_word(pa_q);
                    rdv_seen++;
                end
            end
        end
    end

    // Scoreboard monitor: every cache issue and load beat must match the
    // head of its expectation queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.dc_req && bus.dc_ready) begin
                if (iss_q.size() == 0) begin
                    checkOutput("unexpected_issue", 1, 0);
                end else begin
                    mon_iss = iss_q.pop_front();
                    checkOutput("issue_we", bus.dc_we, mon_iss.we);
                    checkOutput("issue_pa", bus.dc_pa, mon_iss.pa);
                    checkOutput("issue_size", bus.dc_size, mon_iss.size);
                    if (mon_iss.we) checkOutput("issue_wdata", bus.dc_wdata, mon_iss.wdata);
                end
            end
            if (bus.rd_data_v) begin
                if (rsp_q.size() == 0) begin
                    checkOutput("unexpected_rd_data_v", 1, 0);
                end else begin
                    mon_rsp = rsp_q.pop_front();
                    checkOutput("rd_data", bus.rd_data, mon_rsp.data);
                    checkOutput("rd_beat", bus.rd_beat, mon_rsp.beat);
                    checkOutput("rd_ack", bus.rd_ack, mon_rsp.ack);
                end
            end else if (bus.rd_ack) begin
                checkOutput("rd_ack_without_data", 1, 0);
            end
            if (bus.rd_ack) rd_ack_cnt++;
            if (bus.wr_ack) wr_ack_cnt++;
        end
    end

    // Runs one transaction from the table, starting in an IDLE cycle.
    task automatic applyStimulus(input vec_t v);
        bit done;
        int r0;
        int w0;
        r0 = rd_ack_cnt;
        w0 = wr_ack_cnt;
        for (int b = 0; b < (v.spill ? 2 : 1); b++) begin
            iss_q.push_back('{v.is_wr, (b == 1) ? v.pa2 : v.pa1, (b == 1) ? v.size2 : v.size1,
                              v.is_wr ? ((b == 1) ? v.wd2 : v.wd1) : '0});
        end
        if (!v.is_wr) begin
            rsp_q.push_back('{v.exp_rd1, 1'b0, !v.spill});
            if (v.spill) rsp_q.push_back('{v.exp_rd2, 1'b1, 1'b1});
        end
        rd_lat = v.lat;
        bus.dc_ready = (v.stall == 0);
        if (v.is_wr) begin
            bus.wr_pa1 = v.pa1;      bus.wr_pa2 = v.pa2;
            bus.wr_size1 = v.size1;  bus.wr_size2 = v.size2;
            bus.wr_data1 = v.wd1;    bus.wr_data2 = v.wd2;
            bus.wr_spill = v.spill;  bus.wr_req = 1'b1;
        end else begin
            bus.rd_pa1 = v.pa1;      bus.rd_pa2 = v.pa2;
            bus.rd_size1 = v.size1;  bus.rd_size2 = v.size2;
            bus.rd_spill = v.spill;  bus.rd_req = 1'b1;
        end
        @(negedge clk);
        checkOutput("decision_cycle_dc_req", bus.dc_req, 0);
        done = 1'b0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            cycle();
            bus.dc_ready = (cyc >= v.stall);
            @(negedge clk);
            if (cyc == 0) checkOutput("grant_latency_dc_req", bus.dc_req, 1);
            if (v.is_wr ? bus.wr_ack : bus.rd_ack) done = 1'b1;
        end
        if (!done) checkOutput("ack_timeout", 0, 1);
        cycle();
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        cycle();
        checkOutput("issue_queue_drained", iss_q.size(), 0);
        checkOutput("rsp_queue_drained", rsp_q.size(), 0);
        checkOutput("rd_ack_count", rd_ack_cnt - r0, v.is_wr ? 0 : 1);
        checkOutput("wr_ack_count", wr_ack_cnt - w0, v.is_wr ? 1 : 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        bit done;
        bit rd_seen;
        int r0;
        int w0;
        int wb;
        int v0;

        //        wr spill pa1       pa2       sz1   sz2   wd1           wd2           lat stall exp_rd1                 exp_rd2
        vecs[0] = '{0, 0, 15'h0100, 15'h0000, 2'd2, 2'd0, 32'h0,        32'h0,        2,  0,    mem_word(15'h0100), 32'h0};
        vecs[1] = '{0, 1, 15'h01FE, 15'h0200, 2'd1, 2'd1, 32'h0,        32'h0,        1,  0,    mem_word(15'h01FE), mem_word(15'h0200)};
        vecs[2] = '{1, 0, 15'h0040, 15'h0000, 2'd2, 2'd0, 32'hCAFEF00D, 32'h0,        1,  0,    32'h0, 32'h0};
        vecs[3] = '{1, 1, 15'h07FE, 15'h0800, 2'd1, 2'd1, 32'h11223344, 32'h55667788, 1,  0,    32'h0, 32'h0};
        vecs[4] = '{0, 1, 15'h7FFC, 15'h0000, 2'd2, 2'd2, 32'h0,        32'h0,        3,  2,    mem_word(15'h7FFC), mem_word(15'h0000)};
        vecs[5] = '{1, 0, 15'h7FFF, 15'h0000, 2'd0, 2'd0, 32'h000000A5, 32'h0,        1,  3,    32'h0, 32'h0};
        vecs[6] = '{0, 0, 15'h0004, 15'h0000, 2'd0, 2'd0, 32'h0,        32'h0,        1,  1,    mem_word(15'h0004), 32'h0};

        bus.rd_req = 1'b0;  bus.rd_pa1 = '0;  bus.rd_pa2 = '0;  bus.rd_size1 = '0;
        bus.rd_size2 = '0;  bus.rd_spill = 1'b0;  bus.rd_flush = 1'b0;
        bus.wr_req = 1'b0;  bus.wr_pa1 = '0;  bus.wr_pa2 = '0;  bus.wr_size1 = '0;
        bus.wr_size2 = '0;  bus.wr_data1 = '0;  bus.wr_data2 = '0;  bus.wr_spill = 1'b0;
        bus.dc_ready = 1'b1;

        // Reset with both requests active: all outputs stay low.
        rst = 1'b1;
        bus.rd_req = 1'b1;
        bus.wr_req = 1'b1;
        bus.wr_data1 = 32'hFFFFFFFF;
        cycle();
        cycle();
        @(negedge clk);
        checkOutput("reset_dc_req", bus.dc_req, 0);
        checkOutput("reset_dc_wdata", bus.dc_wdata, 0);
        checkOutput("reset_rd_data_v", bus.rd_data_v, 0);
        checkOutput("reset_wr_ack", bus.wr_ack, 0);
        cycle();
        rst = 1'b0;
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_dc_req", bus.dc_req, 0);
        checkOutput("post_reset_dc_pa", bus.dc_pa, 0);
        checkOutput("post_reset_rd_ack", bus.rd_ack, 0);
        cycle();

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

        // Flush while the read is still stalled in issue: abandoned, no DRAIN.
        $display("[TB] flush before issue");
        bus.dc_ready = 1'b0;
        bus.rd_pa1 = 15'h0222;
        bus.rd_size1 = 2'd2;
        bus.rd_spill = 1'b0;
        bus.rd_req = 1'b1;
        cycle();
        bus.rd_flush = 1'b1;
        bus.rd_req = 1'b0;
        @(negedge clk);
        checkOutput("stalled_iss_dc_req", bus.dc_req, 1);
        checkOutput("stalled_iss_dc_pa", bus.dc_pa, 15'h0222);
        cycle();
        bus.rd_flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_iss_back_idle", bus.dc_req, 0);
        cycle();
        applyStimulus(vecs[2]);

        // Flush while waiting for data: the late response is swallowed.
        $display("[TB] flush in wait");
        r0 = rd_ack_cnt;
        rd_lat = 4;
        bus.dc_ready = 1'b1;
        bus.rd_pa1 = 15'h0123;
        bus.rd_size1 = 2'd2;
        bus.rd_spill = 1'b0;
        bus.rd_req = 1'b1;
        iss_q.push_back('{1'b0, 15'h0123, 2'd2, 32'h0});
        cycle();
        @(negedge clk);
        checkOutput("flush_wait_issue", bus.dc_req, 1);
        cycle();
        bus.rd_flush = 1'b1;
        bus.rd_req = 1'b0;
        v0 = rdv_seen;
        @(negedge clk);
        checkOutput("flush_wait_rd_data_v", bus.rd_data_v, 0);
        cycle();
        bus.rd_flush = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            checkOutput("drain_no_issue", bus.dc_req, 0);
            if (rdv_seen != v0) begin
                done = 1'b1;
                checkOutput("drain_drops_data", bus.rd_data_v, 0);
            end
            cycle();
        end
        if (!done) checkOutput("drain_response_timeout", 0, 1);
        checkOutput("flushed_load_no_ack", rd_ack_cnt - r0, 0);
        applyStimulus(vecs[0]);

        // Reset during beat 1 of a spill store, then straight into contention.
        $display("[TB] reset mid-store and starvation");
        w0 = wr_ack_cnt;
        r0 = rd_ack_cnt;
        rd_lat = 1;
        bus.dc_ready = 1'b1;
        bus.rd_pa1 = 15'h0300;
        bus.rd_size1 = 2'd2;
        bus.rd_spill = 1'b0;
        bus.rd_req = 1'b1;
        bus.wr_pa1 = 15'h0640;   bus.wr_pa2 = 15'h0644;
        bus.wr_size1 = 2'd2;     bus.wr_size2 = 2'd2;
        bus.wr_data1 = 32'h11223344;
        bus.wr_data2 = 32'h55667788;
        bus.wr_spill = 1'b1;
        bus.wr_req = 1'b1;
        iss_q.push_back('{1'b1, 15'h0640, 2'd2, 32'h11223344});
        @(negedge clk);
        checkOutput("contend_store_first", bus.dc_req, 0);
        cycle();
        @(negedge clk);
        checkOutput("spill_store_beat0_we", bus.dc_we, 1);
        checkOutput("spill_store_beat0_no_ack", bus.wr_ack, 0);
        cycle();
        rst = 1'b1;
        bus.wr_pa1 = 15'h0500;
        bus.wr_spill = 1'b0;
        bus.wr_data1 = 32'h0BADC0DE;
        iss_q.push_back('{1'b1, 15'h0500, 2'd2, 32'h0BADC0DE});
        iss_q.push_back('{1'b1, 15'h0500, 2'd2, 32'h0BADC0DE});
        iss_q.push_back('{1'b0, 15'h0300, 2'd2, 32'h0});
        rsp_q.push_back('{mem_word(15'h0300), 1'b0, 1'b1});
        @(negedge clk);
        checkOutput("rst_in_wr_iss_dc_req", bus.dc_req, 0);
        checkOutput("rst_in_wr_iss_wr_ack", bus.wr_ack, 0);
        cycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("after_rst_dc_req", bus.dc_req, 0);
        checkOutput("after_rst_wr_ack", bus.wr_ack, 0);
        cycle();
        done = 1'b0;
        rd_seen = 1'b0;
        wb = -1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (bus.dc_req && !bus.dc_we && !rd_seen) begin
                rd_seen = 1'b1;
                wb = wr_ack_cnt - w0;
            end
            if (bus.rd_ack) done = 1'b1;
            cycle();
            if (rd_seen) bus.wr_req = 1'b0;
        end
        if (!done) checkOutput("starved_load_timeout", 0, 1);
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        cycle();
        checkOutput("stores_before_forced_load", wb, 2);
        checkOutput("starve_rd_ack_count", rd_ack_cnt - r0, 1);
        checkOutput("starve_issue_queue_drained", iss_q.size(), 0);
        checkOutput("starve_rsp_queue_drained", rsp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
